// File: rtl/logic_unit_scheduler_if.sv
// Station-side request/operand bus and CDB result handshake for the logic-unit scheduler.
// master = stations/CDB environment, slave = scheduler.
interface logic_unit_scheduler_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic                 FLUSH;
  logic [2:0]           RS_REQ;
  logic [8:0]           RS_OP;
  logic [3*WIDTH-1:0]   RS_A;
  logic [3*WIDTH-1:0]   RS_B;
  logic [3*TAG_W-1:0]   RS_TAG;
  logic [2:0]           RS_GNT;
  logic                 CDB_REQ;
  logic                 CDB_GNT;
  logic [TAG_W-1:0]     CDB_TAG;
  logic [WIDTH-1:0]     CDB_DATA;
  logic                 BUSY;

  modport master (
    output FLUSH, RS_REQ, RS_OP, RS_A, RS_B, RS_TAG, CDB_GNT,
    input  RS_GNT, CDB_REQ, CDB_TAG, CDB_DATA, BUSY
  );

  modport slave (
    input  FLUSH, RS_REQ, RS_OP, RS_A, RS_B, RS_TAG, CDB_GNT,
    output RS_GNT, CDB_REQ, CDB_TAG, CDB_DATA, BUSY
  );
endinterface

// File: rtl/logic_unit_scheduler.sv
// Round-robin scheduler sharing one bitwise logic datapath between three reservation
// stations: EX operand capture, WB result register held until the CDB accepts it.
module logic_unit_scheduler #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  logic_unit_scheduler_if.slave   bus
);

  logic               r_ex_valid;
  logic [2:0]         r_ex_op;
  logic [WIDTH-1:0]   r_ex_a;
  logic [WIDTH-1:0]   r_ex_b;
  logic [TAG_W-1:0]   r_ex_tag;
  logic               r_wb_valid;
  logic [WIDTH-1:0]   r_wb_data;
  logic [TAG_W-1:0]   r_wb_tag;
  logic [1:0]         r_rr;

  logic               w_drain;
  logic               w_adv;
  logic               w_can_issue;
  logic               w_found;
  logic [1:0]         w_sel;
  logic [1:0]         w_cand [3];
  logic [2:0]         w_gnt;
  logic [2:0]         w_op;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [TAG_W-1:0]   w_tag;
  logic [WIDTH-1:0]   w_result;

  assign w_drain     = r_wb_valid & bus.CDB_GNT;
  assign w_adv       = r_ex_valid & (~r_wb_valid | w_drain);
  assign w_can_issue = ~r_ex_valid | w_adv;

  // Scan order rr, rr+1, rr+2 (mod 3); no grant while reset/FLUSH so nothing is consumed.
  always_comb begin
    w_cand[0] = r_rr;
    w_cand[1] = (r_rr == 2'd2) ? 2'd0 : r_rr + 2'd1;
    w_cand[2] = (r_rr == 2'd0) ? 2'd2 : r_rr - 2'd1;
    w_found   = 1'b0;
    w_sel     = 2'd0;
    if (w_can_issue && !reset && !bus.FLUSH) begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (!w_found && bus.RS_REQ[w_cand[k]]) begin
          w_found = 1'b1;
          w_sel   = w_cand[k];
        end
      end
    end
    w_gnt = '0;
    if (w_found) w_gnt[w_sel] = 1'b1;
  end

  always_comb begin
    w_op  = '0;
    w_a   = '0;
    w_b   = '0;
    w_tag = '0;
    for (int unsigned s = 0; s < 3; s++) begin
      if (w_sel == 2'(s)) begin
        w_op  = bus.RS_OP[3*s +: 3];
        w_a   = bus.RS_A[WIDTH*s +: WIDTH];
        w_b   = bus.RS_B[WIDTH*s +: WIDTH];
        w_tag = bus.RS_TAG[TAG_W*s +: TAG_W];
      end
    end
  end

  always_comb begin
    case (r_ex_op)
      3'b000:  w_result = r_ex_a & r_ex_b;
      3'b001:  w_result = r_ex_a | r_ex_b;
      3'b010:  w_result = ~(r_ex_a & r_ex_b);
      3'b011:  w_result = ~(r_ex_a | r_ex_b);
      3'b100:  w_result = r_ex_a ^ r_ex_b;
      3'b101:  w_result = ~(r_ex_a ^ r_ex_b);
      3'b110:  w_result = ~r_ex_a;
      default: w_result = r_ex_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_tag   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_tag   <= '0;
      r_rr       <= 2'd0;
    end else if (bus.FLUSH) begin
      // CDB_DATA/CDB_TAG deliberately keep their last values across a flush.
      r_ex_valid <= 1'b0;
      r_wb_valid <= 1'b0;
      r_rr       <= 2'd0;
    end else begin
      if (w_found) begin
        r_ex_valid <= 1'b1;
        r_ex_op    <= w_op;
        r_ex_a     <= w_a;
        r_ex_b     <= w_b;
        r_ex_tag   <= w_tag;
        r_rr       <= (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
      end else if (w_adv) begin
        r_ex_valid <= 1'b0;
      end
      if (w_adv) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= w_result;
        r_wb_tag   <= r_ex_tag;
      end else if (w_drain) begin
        r_wb_valid <= 1'b0;
      end
    end
  end

  assign bus.RS_GNT   = w_gnt;
  assign bus.CDB_REQ  = r_wb_valid;
  assign bus.CDB_DATA = r_wb_data;
  assign bus.CDB_TAG  = r_wb_tag;
  assign bus.BUSY     = r_ex_valid | r_wb_valid;

endmodule
